// File: rtl/snake_pkg.sv
// snake_pkg: shared grid constants, direction/state encodings and init helpers for the snake body controller
package snake_pkg;
  localparam int GRID_W = 80;
  localparam int GRID_H = 60;
  localparam int MAX_LEN = 480;
  localparam int COORD_W = 7;
  localparam logic [COORD_W-1:0] EMPTY = 7'h7F;
  localparam logic [1:0] DIR_UP = 2'b00;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DEAD} state_t;
  // Opposite directions differ only in bit 0.
  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return {dir[1], ~dir[0]};
  endfunction
  function automatic logic [COORD_W-1:0] init_x(input int i);
    return i < 3 ? COORD_W'(40 - i) : EMPTY;
  endfunction
  function automatic logic [COORD_W-1:0] init_y(input int i);
    return i < 3 ? COORD_W'(30) : EMPTY;
  endfunction
endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: next head cell for a direction, flagging moves that leave the grid
module snake_next_head #(
  parameter int GRID_W = snake_pkg::GRID_W,
  parameter int GRID_H = snake_pkg::GRID_H
) (
  input  logic [snake_pkg::COORD_W-1:0] head_x,
  input  logic [snake_pkg::COORD_W-1:0] head_y,
  input  logic [1:0]                    dir,
  output logic [snake_pkg::COORD_W-1:0] next_x,
  output logic [snake_pkg::COORD_W-1:0] next_y,
  output logic                          oob
);
  import snake_pkg::*;
  logic [COORD_W:0] x_inc, y_inc;
  // Underflow is caught by testing for zero, so the wrapped decrement is never trusted.
  always_comb begin
    x_inc = (COORD_W+1)'(head_x) + (COORD_W+1)'(1);
    y_inc = (COORD_W+1)'(head_y) + (COORD_W+1)'(1);
    next_x = dir == DIR_LEFT ? head_x - COORD_W'(1) : dir == DIR_RIGHT ? x_inc[COORD_W-1:0] : head_x;
    next_y = dir == DIR_UP ? head_y - COORD_W'(1) : dir == DIR_DOWN ? y_inc[COORD_W-1:0] : head_y;
    oob = dir == DIR_UP ? head_y == '0 :
          dir == DIR_DOWN ? y_inc >= (COORD_W+1)'(GRID_H) :
          dir == DIR_LEFT ? head_x == '0 : x_inc >= (COORD_W+1)'(GRID_W);
  end
endmodule

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: holds the snake body, advances it per tick, grows on eating and detects wall/self collisions
module snake_body_ctrl #(
  parameter int GRID_W = snake_pkg::GRID_W,
  parameter int GRID_H = snake_pkg::GRID_H,
  parameter int MAX_LEN = snake_pkg::MAX_LEN
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Tick,
  input  logic [1:0]           i_Dir,
  input  logic                 i_Restart,
  input  logic [6:0]           i_Item_x,
  input  logic [6:0]           i_Item_y,
  output logic [MAX_LEN*7-1:0] o_Body_x,
  output logic [MAX_LEN*7-1:0] o_Body_y,
  output logic [8:0]           o_Body_size,
  output logic                 o_Eat,
  output logic                 o_Dead,
  output logic                 o_Busy
);
  import snake_pkg::*;
  state_t state_q, state_d;
  logic [COORD_W-1:0] bx_q [MAX_LEN];
  logic [COORD_W-1:0] bx_d [MAX_LEN];
  logic [COORD_W-1:0] by_q [MAX_LEN];
  logic [COORD_W-1:0] by_d [MAX_LEN];
  logic [8:0] size_q, size_d, cnt_q, cnt_d;
  logic [1:0] cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
  logic eat_q, eat_d, hit_item, oob;
  logic [COORD_W-1:0] nx, ny;
  snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
    .head_x(bx_q[0]),
    .head_y(by_q[0]),
    .dir(pend_dir_q),
    .next_x(nx),
    .next_y(ny),
    .oob(oob)
  );
  always_comb begin
    state_d = state_q;
    bx_d = bx_q;
    by_d = by_q;
    size_d = size_q;
    cnt_d = cnt_q;
    cur_dir_d = cur_dir_q;
    eat_d = 1'b0;
    pend_dir_d = i_Dir == opposite(cur_dir_q) ? pend_dir_q : i_Dir;
    hit_item = nx == i_Item_x && ny == i_Item_y;
    if (state_q == ST_IDLE && i_Tick) begin
      if (oob) begin
        state_d = ST_DEAD;
      end else begin
        for (int i = 1; i < MAX_LEN; i++) begin
          bx_d[i] = bx_q[i-1];
          by_d[i] = by_q[i-1];
        end
        bx_d[0] = nx;
        by_d[0] = ny;
        cur_dir_d = pend_dir_q;
        eat_d = hit_item;
        // A saturated body has no slot at index size; the shift already dropped the tail.
        if (hit_item) size_d = size_q == 9'(MAX_LEN) ? size_q : size_q + 9'd1;
        else for (int i = 1; i < MAX_LEN; i++) if (9'(i) == size_q) begin
          bx_d[i] = EMPTY;
          by_d[i] = EMPTY;
        end
        cnt_d = 9'd1;
        state_d = ST_CHECK;
      end
    end else if (state_q == ST_CHECK) begin
      if (bx_q[cnt_q] == bx_q[0] && by_q[cnt_q] == by_q[0]) state_d = ST_DEAD;
      else if (cnt_q == size_q - 9'd1) state_d = ST_IDLE;
      else cnt_d = cnt_q + 9'd1;
    end else if (state_q == ST_DEAD && i_Restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        bx_d[i] = init_x(i);
        by_d[i] = init_y(i);
      end
      size_d = 9'd3;
      cnt_d = '0;
      cur_dir_d = DIR_RIGHT;
      pend_dir_d = DIR_RIGHT;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      size_q <= 9'd3;
      cnt_q <= '0;
      cur_dir_q <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      eat_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        bx_q[i] <= init_x(i);
        by_q[i] <= init_y(i);
      end
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
      cur_dir_q <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      eat_q <= eat_d;
      bx_q <= bx_d;
      by_q <= by_d;
    end
  end
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign o_Body_x[g*COORD_W +: COORD_W] = bx_q[g];
    assign o_Body_y[g*COORD_W +: COORD_W] = by_q[g];
  end
  assign o_Body_size = size_q;
  assign o_Eat = eat_q;
  assign o_Dead = state_q == ST_DEAD;
  assign o_Busy = state_q == ST_CHECK;
endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl: queue-based model of the snake feeding a scoreboard checked at each move completion
module tb_snake_body_ctrl;
  localparam int GW = 80;
  localparam int GH = 60;
  localparam int ML = 480;
  localparam int CW = 7;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, restart = 1'b0;
  logic [1:0] dir = RIGHT;
  logic [6:0] item_x = 7'd10, item_y = 7'd10;
  logic [ML*CW-1:0] body_x, body_y;
  logic [8:0] body_size;
  logic eat, dead, busy;
  int checks = 0, fails = 0;

  typedef struct {
    int size;
    bit dead;
    int busy;
    int eat;
    logic [ML*CW-1:0] bx;
    logic [ML*CW-1:0] by;
  } exp_t;
  exp_t sbq[$];

  int mx[$], my[$];
  logic [1:0] m_cur, m_pend;
  bit m_dead, m_die;
  int m_busy;
  logic [1:0] opp [4] = '{DOWN, UP, RIGHT, LEFT};

  snake_body_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick), .i_Dir(dir), .i_Restart(restart),
    .i_Item_x(item_x), .i_Item_y(item_y), .o_Body_x(body_x), .o_Body_y(body_y),
    .o_Body_size(body_size), .o_Eat(eat), .o_Dead(dead), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int step(input int c, input logic [1:0] d, input bit is_x);
    if (is_x) return c + (d == RIGHT ? 1 : d == LEFT ? -1 : 0);
    return c + (d == DOWN ? 1 : d == UP ? -1 : 0);
  endfunction

  task automatic model_init();
    mx = {40, 39, 38};
    my = {30, 30, 30};
    m_cur = RIGHT;
    m_pend = RIGHT;
    m_dead = 0;
    m_die = 0;
    m_busy = 0;
  endtask

  task automatic push_exp(input bit d, input int b, input int e);
    exp_t x;
    x.size = mx.size();
    x.dead = d;
    x.busy = b;
    x.eat = e;
    for (int i = 0; i < ML; i++) begin
      x.bx[i*CW +: CW] = i < mx.size() ? CW'(mx[i]) : 7'h7F;
      x.by[i*CW +: CW] = i < my.size() ? CW'(my[i]) : 7'h7F;
    end
    sbq.push_back(x);
  endtask

  // Advances the model by one clock, given the inputs driven for that clock.
  task automatic model_step(input bit t, input logic [1:0] d, input bit r, input int ix, input int iy);
    logic [1:0] pn;
    int nx, ny, k;
    bit ate;
    pn = d == opp[m_cur] ? m_pend : d;
    if (m_dead) begin
      if (r) begin
        model_init();
        pn = RIGHT;
        push_exp(0, 0, 0);
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0 && m_die) m_dead = 1;
    end else if (t) begin
      nx = step(mx[0], m_pend, 1);
      ny = step(my[0], m_pend, 0);
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        m_dead = 1;
        push_exp(1, 0, 0);
      end else begin
        m_cur = m_pend;
        ate = nx == ix && ny == iy;
        mx.push_front(nx);
        my.push_front(ny);
        if (!ate || mx.size() > ML) begin
          void'(mx.pop_back());
          void'(my.pop_back());
        end
        k = 0;
        for (int i = 1; i < mx.size(); i++) if (k == 0 && mx[i] == nx && my[i] == ny) k = i;
        m_die = k != 0;
        m_busy = m_die ? k : mx.size() - 1;
        push_exp(m_die, m_busy, ate ? 1 : 0);
      end
    end
    m_pend = pn;
  endtask

  task automatic cyc(input bit t, input logic [1:0] d, input bit r, input int ix, input int iy);
    tick = t;
    dir = d;
    restart = r;
    item_x = 7'(ix);
    item_y = 7'(iy);
    model_step(t, d, r, ix, iy);
    @(negedge clk);
  endtask

  task automatic move(input logic [1:0] d, input int ix, input int iy);
    cyc(0, d, 0, ix, iy);
    cyc(1, d, 0, ix, iy);
    for (int n = 0; n < ML && m_busy > 0; n++) cyc(0, d, 0, ix, iy);
  endtask

  function automatic int sx(input int i);
    return int'(body_x[i*CW +: CW]);
  endfunction
  function automatic int sy(input int i);
    return int'(body_y[i*CW +: CW]);
  endfunction

  // Monitor: each transaction ends in exactly one of busy falling, dead rising or dead falling.
  initial begin
    bit pb, pd, ok;
    int bc, ec, bad;
    exp_t e;
    pb = 0;
    pd = 0;
    bc = 0;
    ec = 0;
    wait (!rst);
    forever begin
      @(negedge clk);
      if (busy) bc++;
      if (eat) ec++;
      if (dead !== pd || (pb && !busy)) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event: got dead=%0d busy=%0d expected no event", dead, busy);
        end else begin
          e = sbq.pop_front();
          check("size", int'(body_size), e.size);
          check("dead", int'(dead), int'(e.dead));
          check("busy_cycles", bc, e.busy);
          check("eat_pulses", ec, e.eat);
          ok = 1;
          bad = 0;
          for (int i = 0; i < ML; i++)
            if (ok && (body_x[i*CW +: CW] !== e.bx[i*CW +: CW] || body_y[i*CW +: CW] !== e.by[i*CW +: CW])) begin
              ok = 0;
              bad = i;
            end
          checks++;
          if (!ok) begin
            fails++;
            $display("FAIL body slot %0d: got (%0d,%0d) expected (%0d,%0d)", bad, sx(bad), sy(bad),
                     int'(e.bx[bad*CW +: CW]), int'(e.by[bad*CW +: CW]));
          end
        end
        bc = 0;
        ec = 0;
      end
      pb = busy;
      pd = dead;
    end
  end

  initial begin
    logic [1:0] rd;
    bit rt, rr;
    int ix, iy;
    model_init();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_size", int'(body_size), 3);
    check("rst_s0x", sx(0), 40);
    check("rst_s0y", sy(0), 30);
    check("rst_s1x", sx(1), 39);
    check("rst_s2x", sx(2), 38);
    check("rst_s3x", sx(3), 127);
    check("rst_s3y", sy(3), 127);
    check("rst_dead", int'(dead), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_eat", int'(eat), 0);

    move(RIGHT, 10, 10);
    check("move_head_x", sx(0), 41);
    move(RIGHT, 42, 30);
    check("eat_size", int'(body_size), 4);
    cyc(0, LEFT, 0, 10, 10);
    move(LEFT, 10, 10);
    check("reverse_ignored_x", sx(0), 43);
    for (int n = 0; n < 40 && !m_dead; n++) move(UP, 10, 10);
    check("wall_dead", int'(dead), 1);
    check("wall_head_y", sy(0), 0);
    cyc(0, RIGHT, 1, 10, 10);
    check("restart_dead", int'(dead), 0);
    check("restart_head_x", sx(0), 40);

    move(RIGHT, 41, 30);
    move(RIGHT, 42, 30);
    check("grow_size", int'(body_size), 5);
    move(DOWN, 10, 10);
    move(LEFT, 10, 10);
    move(UP, 10, 10);
    check("self_dead", int'(dead), 1);

    cyc(1, RIGHT, 1, 10, 10);
    cyc(0, RIGHT, 0, 10, 10);
    cyc(1, RIGHT, 0, 10, 10);
    cyc(1, RIGHT, 0, 10, 10);
    cyc(1, RIGHT, 0, 10, 10);
    for (int n = 0; n < ML && m_busy > 0; n++) cyc(0, RIGHT, 0, 10, 10);
    check("tick_in_check_x", sx(0), 41);

    for (int n = 0; n < 4000; n++) begin
      rd = 2'($urandom_range(0, 3));
      rt = $urandom_range(0, 3) == 0;
      rr = $urandom_range(0, 7) == 0;
      ix = $urandom_range(0, GW - 1);
      iy = $urandom_range(0, GH - 1);
      if ($urandom_range(0, 2) == 0 && !m_dead) begin
        ix = step(mx[0], m_pend, 1);
        iy = step(my[0], m_pend, 0);
      end
      cyc(rt, rd, rr, ix, iy);
    end
    tick = 1'b0;
    restart = 1'b0;
    for (int n = 0; n < 2 * ML && sbq.size() > 0; n++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
